multicycle_control: RTL

Main control finite-state machine for the multi-cycle MIPS datapath, sequencing each instruction through fetch, decode, execute, memory and writeback. It is the producing end of the `ALUOp` interface:
- `00`: add.
- `01`: ALU operation selected by opcode (ori/beq).
- `10`: ALU operation selected by funct (addu/subu).

It also drives every datapath mux and write-enable, and stalls on a memory ready handshake.

---
 rtl/multicycle_control.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/execute/memory/writeback
// and decodes every datapath mux select and write-enable from the current state.
module multicycle_control (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       IRWrite,
   output logic       ALUSrcA,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       ExtOp,
   output logic [1:0] ALUOp,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic       illegal_op,
   output logic [3:0] state
);

   localparam int unsigned OP_W = 6;

   localparam logic [OP_W-1:0] OP_R   = 6'b000000;
   localparam logic [OP_W-1:0] OP_ORI = 6'b001101;
   localparam logic [OP_W-1:0] OP_BEQ = 6'b000100;
   localparam logic [OP_W-1:0] OP_LW  = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW  = 6'b101011;
   localparam logic [OP_W-1:0] OP_J   = 6'b000010;

   typedef enum logic [3:0] {
      INIT      = 4'd0,
      FETCH     = 4'd1,
      DECODE    = 4'd2,
      MEM_ADDR  = 4'd3,
      MEM_READ  = 4'd4,
      MEM_WB    = 4'd5,
      MEM_WRITE = 4'd6,
      R_EXEC    = 4'd7,
      R_WB      = 4'd8,
      ORI_EXEC  = 4'd9,
      ORI_WB    = 4'd10,
      BRANCH    = 4'd11,
      JUMP      = 4'd12,
      TRAP      = 4'd13
   } state_t;

   state_t state_q;
   state_t state_d;

   // State register; reset aborts any instruction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= INIT;
      else        state_q <= state_d;
   end

   assign state = state_q;

   // Next-state and Moore output decode; FETCH strobes are additionally gated by mem_ready.
   always_comb begin
      state_d     = state_q;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      ALUSrcA     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      ExtOp       = 1'b0;
      ALUOp       = 2'b00;
      ALUSrcB     = 2'b00;
      PCSource    = 2'b00;
      illegal_op  = 1'b0;

      case (state_q)
         INIT: state_d = FETCH;

         FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            if (mem_ready) state_d = DECODE;
         end

         DECODE: begin
            ALUSrcB = 2'b11;
            ExtOp   = 1'b1;
            case (opcode)
               OP_LW, OP_SW: state_d = MEM_ADDR;
               OP_R:         state_d = R_EXEC;
               OP_ORI:       state_d = ORI_EXEC;
               OP_BEQ:       state_d = BRANCH;
               OP_J:         state_d = JUMP;
               default:      state_d = TRAP;
            endcase
         end

         MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ExtOp   = 1'b1;
            state_d = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
         end

         MEM_READ: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready) state_d = MEM_WB;
         end

         MEM_WB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
            state_d  = FETCH;
         end

         MEM_WRITE: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (mem_ready) state_d = FETCH;
         end

         R_EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
            state_d = R_WB;
         end

         R_WB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
            state_d  = FETCH;
         end

         ORI_EXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ALUOp   = 2'b01;
            state_d = ORI_WB;
         end

         ORI_WB: begin
            RegWrite = 1'b1;
            state_d  = FETCH;
         end

         BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = 2'b01;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            state_d     = FETCH;
         end

         JUMP: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
            state_d  = FETCH;
         end

         TRAP: begin
            illegal_op = 1'b1;
            state_d    = FETCH;
         end

         // Unused codes behave as INIT and recover through it.
         default: state_d = INIT;
      endcase
   end

endmodule
